// File: rtl/fa_bist_checker.sv
// fa_bist_checker: on-chip self-test engine for a full-adder cell.
// Sweeps all eight {a,b,c} vectors PASSES times, compares the adder's
// {co,s} against the arithmetic sum after LAT cycles of latency, and
// reports a saturating mismatch count, the first failing vector and a
// pass/fail verdict.
module fa_bist_checker #(
    parameter int LAT    = 1,
    parameter int PASSES = 2,
    parameter int ERRW   = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic            fa_a,
    output logic            fa_b,
    output logic            fa_c,
    input  logic            fa_s,
    input  logic            fa_co,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [ERRW-1:0] err_cnt,
    output logic [2:0]      first_err_vec,
    output logic            first_err_valid
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [7:0]      LAST_PASS  = 8'(PASSES - 1);
    localparam logic [2:0]      LAST_DRAIN = 3'((LAT > 0) ? (LAT - 1) : 0);
    localparam logic [ERRW-1:0] ERR_MAX    = {ERRW{1'b1}};
    localparam int              PD         = (LAT > 0) ? LAT : 1;

    // Reference response of an ideal full adder: {co,s} = a+b+c.
    function automatic logic [1:0] fa_golden(input logic [2:0] v);
        logic [1:0] r;
        r = {1'b0, v[2]} + {1'b0, v[1]} + {1'b0, v[0]};
        return r;
    endfunction

    state_t          state_r, state_s;
    logic [2:0]      vec_r, vec_s;
    logic [7:0]      pass_cnt_r, pass_cnt_s;
    logic [2:0]      drain_cnt_r, drain_cnt_s;
    logic            clear_s;
    logic            busy_r, done_r, pass_r, pass_s;
    logic [ERRW-1:0] err_cnt_r, err_cnt_s;
    logic [2:0]      fev_r, fev_s;
    logic            fvalid_r, fvalid_s;
    logic            chk_valid_s;
    logic [1:0]      chk_exp_s;
    logic [2:0]      chk_vec_s;
    logic            mismatch_s;

    // Next-state logic: vector/pass sequencing and drain timing.
    always_comb begin
        state_s     = state_r;
        vec_s       = 3'd0;
        pass_cnt_s  = pass_cnt_r;
        drain_cnt_s = 3'd0;
        clear_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s    = DRIVE;
                    pass_cnt_s = 8'd0;
                    clear_s    = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            DRIVE: begin
                if ((vec_r == 3'd7) && (pass_cnt_r == LAST_PASS)) begin
                    state_s = (LAT == 0) ? DONE : DRAIN;
                end else begin
                    vec_s = vec_r + 3'd1;
                    if (vec_r == 3'd7) begin
                        pass_cnt_s = pass_cnt_r + 8'd1;
                    end else begin
                        pass_cnt_s = pass_cnt_r;
                    end
                end
            end
            DRAIN: begin
                if (drain_cnt_r == LAST_DRAIN) begin
                    state_s = DONE;
                end else begin
                    drain_cnt_s = drain_cnt_r + 3'd1;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Expected response travels alongside the external adder's latency.
    generate
        if (LAT == 0) begin : g_no_lat
            assign chk_valid_s = (state_r == DRIVE);
            assign chk_exp_s   = fa_golden(vec_r);
            assign chk_vec_s   = vec_r;
        end else begin : g_lat
            logic       pv_r [PD];
            logic [1:0] pe_r [PD];
            logic [2:0] pvec_r [PD];

            // Delay line of {valid, expected, vector}, cleared on reset.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < PD; i++) begin
                        pv_r[i]   <= 1'b0;
                        pe_r[i]   <= 2'd0;
                        pvec_r[i] <= 3'd0;
                    end
                end else begin
                    pv_r[0]   <= (state_r == DRIVE);
                    pe_r[0]   <= fa_golden(vec_r);
                    pvec_r[0] <= vec_r;
                    for (int i = 1; i < PD; i++) begin
                        pv_r[i]   <= pv_r[i-1];
                        pe_r[i]   <= pe_r[i-1];
                        pvec_r[i] <= pvec_r[i-1];
                    end
                end
            end

            assign chk_valid_s = pv_r[PD-1];
            assign chk_exp_s   = pe_r[PD-1];
            assign chk_vec_s   = pvec_r[PD-1];
        end
    endgenerate

    assign mismatch_s = chk_valid_s && ({fa_co, fa_s} != chk_exp_s);

    // Result bookkeeping: saturating count, first failure, verdict.
    always_comb begin
        err_cnt_s = err_cnt_r;
        fev_s     = fev_r;
        fvalid_s  = fvalid_r;
        pass_s    = pass_r;
        if (clear_s) begin
            err_cnt_s = {ERRW{1'b0}};
            fev_s     = 3'd0;
            fvalid_s  = 1'b0;
            pass_s    = 1'b0;
        end else begin
            if (mismatch_s && (err_cnt_r != ERR_MAX)) begin
                err_cnt_s = err_cnt_r + {{(ERRW-1){1'b0}}, 1'b1};
            end else begin
                err_cnt_s = err_cnt_r;
            end
            if (mismatch_s && !fvalid_r) begin
                fev_s    = chk_vec_s;
                fvalid_s = 1'b1;
            end else begin
                fev_s    = fev_r;
                fvalid_s = fvalid_r;
            end
            if (state_s == DONE) begin
                pass_s = (err_cnt_s == {ERRW{1'b0}});
            end else begin
                pass_s = pass_r;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            vec_r       <= 3'd0;
            pass_cnt_r  <= 8'd0;
            drain_cnt_r <= 3'd0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            pass_r      <= 1'b0;
            err_cnt_r   <= {ERRW{1'b0}};
            fev_r       <= 3'd0;
            fvalid_r    <= 1'b0;
        end else begin
            state_r     <= state_s;
            vec_r       <= vec_s;
            pass_cnt_r  <= pass_cnt_s;
            drain_cnt_r <= drain_cnt_s;
            busy_r      <= (state_s == DRIVE) || (state_s == DRAIN);
            done_r      <= (state_s == DONE);
            pass_r      <= pass_s;
            err_cnt_r   <= err_cnt_s;
            fev_r       <= fev_s;
            fvalid_r    <= fvalid_s;
        end
    end

    // vec_r is held at zero outside DRIVE, so it feeds the adder directly.
    assign {fa_a, fa_b, fa_c} = vec_r;
    assign busy            = busy_r;
    assign done            = done_r;
    assign pass            = pass_r;
    assign err_cnt         = err_cnt_r;
    assign first_err_vec   = fev_r;
    assign first_err_valid = fvalid_r;

endmodule

// File: tb/tb_fa_bist_checker.sv
// Bench for fa_bist_checker: four engines with different latency, sweep
// count and counter width, each beside a behavioural adder that can be
// made faulty. Expected vectors are queued at start and popped per cycle.
module tb_fa_bist_checker;

    localparam int LATS [0:3] = '{1, 0, 3, 1};
    localparam int PS   [0:3] = '{2, 1, 1, 1};
    localparam int EW   [0:3] = '{8, 8, 8, 2};

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start_v [4];
    int         mode [4];
    logic [2:0] vec [4];
    logic       busy_v [4];
    logic       done_v [4];
    logic       pass_v [4];
    logic [7:0] err_v [4];
    logic [2:0] fev_v [4];
    logic       fval_v [4];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic [1:0] golden(input logic [2:0] v);
        logic [1:0] r;
        r = {1'b0, v[2]} + {1'b0, v[1]} + {1'b0, v[0]};
        return r;
    endfunction

    // mode 0: good adder, 1: carry stuck at 0, 2: sum inverted
    function automatic logic [1:0] fault_resp(input int m, input logic [2:0] v);
        logic [1:0] r;
        r = golden(v);
        if (m == 1) r[1] = 1'b0;
        else if (m == 2) r[0] = ~r[0];
        return r;
    endfunction

    for (genvar g = 0; g < 4; g++) begin : g_dut
        logic             a_l, b_l, c_l, busy_l, done_l, pass_l, fval_l;
        logic [2:0]       fev_l;
        logic [EW[g]-1:0] ec_l;
        logic [1:0]       pipe [0:7];
        logic [1:0]       resp;

        always @(posedge clk) begin
            pipe[0] <= fault_resp(mode[g], {a_l, b_l, c_l});
            for (int k = 1; k < 8; k++) pipe[k] <= pipe[k-1];
        end

        assign resp = (LATS[g] == 0) ? fault_resp(mode[g], {a_l, b_l, c_l})
                                     : pipe[(LATS[g] == 0) ? 0 : LATS[g] - 1];

        fa_bist_checker #(.LAT(LATS[g]), .PASSES(PS[g]), .ERRW(EW[g])) u_dut (
            .clk            (clk),
            .rst_n          (rst_n),
            .start          (start_v[g]),
            .fa_a           (a_l),
            .fa_b           (b_l),
            .fa_c           (c_l),
            .fa_s           (resp[0]),
            .fa_co          (resp[1]),
            .busy           (busy_l),
            .done           (done_l),
            .pass           (pass_l),
            .err_cnt        (ec_l),
            .first_err_vec  (fev_l),
            .first_err_valid(fval_l)
        );

        assign vec[g]    = {a_l, b_l, c_l};
        assign busy_v[g] = busy_l;
        assign done_v[g] = done_l;
        assign pass_v[g] = pass_l;
        assign err_v[g]  = 8'(ec_l);
        assign fev_v[g]  = fev_l;
        assign fval_v[g] = fval_l;
    end

    // One run on engine i; repulse_at re-raises start in that cycle,
    // abort_at pulls rst_n low in that cycle and ends the run.
    task automatic run_bist(input int i, input int repulse_at, input int abort_at);
        logic [2:0] q [$];
        logic [2:0] ev;
        int exp_err = 0;
        int max_err;
        logic [2:0] exp_fev = 3'd0;
        logic exp_fval = 1'b0;
        int lat, p, total;
        lat = LATS[i];
        p = PS[i];
        total = 8 * p + lat + 1;
        max_err = (1 << EW[i]) - 1;
        for (int pp = 0; pp < p; pp++) begin
            for (int v = 0; v < 8; v++) begin
                ev = 3'(v);
                q.push_back(ev);
                if (fault_resp(mode[i], ev) != golden(ev)) begin
                    if (exp_err < max_err) exp_err++;
                    if (!exp_fval) begin
                        exp_fval = 1'b1;
                        exp_fev = ev;
                    end
                end
            end
        end
        @(negedge clk);
        start_v[i] = 1'b1;
        @(negedge clk);
        start_v[i] = 1'b0;
        for (int c = 1; c <= total + 1; c++) begin
            if (c == 1) begin
                checks++;
                if (pass_v[i] !== 1'b0 || err_v[i] !== 8'd0 || fval_v[i] !== 1'b0) begin
                    errors++;
                    $display("FAIL clear_on_start eng=%0d got pass=%b err=%0d fval=%b exp 0/0/0",
                             i, pass_v[i], err_v[i], fval_v[i]);
                end
            end
            if (c <= 8 * p) begin
                ev = q.pop_front();
                checks++;
                if (vec[i] !== ev || busy_v[i] !== 1'b1 || done_v[i] !== 1'b0) begin
                    errors++;
                    $display("FAIL drive eng=%0d cyc=%0d got vec=%b busy=%b done=%b exp vec=%b busy=1 done=0",
                             i, c, vec[i], busy_v[i], done_v[i], ev);
                end
            end else if (c <= 8 * p + lat) begin
                checks++;
                if (vec[i] !== 3'd0 || busy_v[i] !== 1'b1 || done_v[i] !== 1'b0) begin
                    errors++;
                    $display("FAIL drain eng=%0d cyc=%0d got vec=%b busy=%b done=%b exp 000/1/0",
                             i, c, vec[i], busy_v[i], done_v[i]);
                end
            end else if (c == total) begin
                checks++;
                if (done_v[i] !== 1'b1 || busy_v[i] !== 1'b0 || vec[i] !== 3'd0) begin
                    errors++;
                    $display("FAIL done_timing eng=%0d cyc=%0d got done=%b busy=%b exp done=1 busy=0",
                             i, c, done_v[i], busy_v[i]);
                end
                checks++;
                if (pass_v[i] !== (exp_err == 0) || err_v[i] !== 8'(exp_err) ||
                    fval_v[i] !== exp_fval || fev_v[i] !== exp_fev) begin
                    errors++;
                    $display("FAIL verdict eng=%0d got pass=%b err=%0d fev=%b fval=%b exp pass=%b err=%0d fev=%b fval=%b",
                             i, pass_v[i], err_v[i], fev_v[i], fval_v[i],
                             exp_err == 0, exp_err, exp_fev, exp_fval);
                end
            end else begin
                checks++;
                if (done_v[i] !== 1'b0 || busy_v[i] !== 1'b0 || pass_v[i] !== (exp_err == 0)) begin
                    errors++;
                    $display("FAIL after_done eng=%0d got done=%b busy=%b pass=%b exp 0/0/%b",
                             i, done_v[i], busy_v[i], pass_v[i], exp_err == 0);
                end
            end
            start_v[i] = (c == repulse_at);
            if (c == abort_at) begin
                rst_n = 1'b0;
                #1;
                checks++;
                if (vec[i] !== 3'd0 || busy_v[i] !== 1'b0 || done_v[i] !== 1'b0 || pass_v[i] !== 1'b0 ||
                    err_v[i] !== 8'd0 || fev_v[i] !== 3'd0 || fval_v[i] !== 1'b0) begin
                    errors++;
                    $display("FAIL abort_reset eng=%0d got vec=%b busy=%b done=%b pass=%b err=%0d exp all zero",
                             i, vec[i], busy_v[i], done_v[i], pass_v[i], err_v[i]);
                end
                @(negedge clk);
                rst_n = 1'b1;
                for (int k = 0; k < total; k++) begin
                    @(negedge clk);
                    checks++;
                    if (done_v[i] !== 1'b0 || busy_v[i] !== 1'b0) begin
                        errors++;
                        $display("FAIL abort_no_done eng=%0d got done=%b busy=%b exp 0/0",
                                 i, done_v[i], busy_v[i]);
                    end
                end
                return;
            end
            @(negedge clk);
        end
        start_v[i] = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (vec[i] !== 3'd0 || busy_v[i] !== 1'b0 || done_v[i] !== 1'b0 || pass_v[i] !== 1'b0 ||
                err_v[i] !== 8'd0 || fev_v[i] !== 3'd0 || fval_v[i] !== 1'b0) begin
                errors++;
                $display("FAIL reset eng=%0d got vec=%b busy=%b done=%b pass=%b err=%0d fev=%b fval=%b exp all zero",
                         i, vec[i], busy_v[i], done_v[i], pass_v[i], err_v[i], fev_v[i], fval_v[i]);
            end
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_golden();
        mode[0] = 0;
        run_bist(0, -1, -1);
    endtask

    task automatic test_stuck_co();
        mode[0] = 1;
        run_bist(0, -1, -1);
        mode[0] = 0;
    endtask

    task automatic test_saturation();
        mode[3] = 2;
        run_bist(3, -1, -1);
        mode[3] = 0;
    endtask

    task automatic test_latency();
        run_bist(1, -1, -1);
        run_bist(2, -1, -1);
    endtask

    task automatic test_restart_ignored();
        run_bist(0, 5, -1);
        run_bist(0, 17, -1);
    endtask

    task automatic test_abort();
        run_bist(0, -1, 6);
        run_bist(0, -1, -1);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            start_v[i] = 1'b0;
            mode[i] = 0;
        end
        test_reset();
        test_golden();
        test_stuck_co();
        test_saturation();
        test_latency();
        test_restart_ignored();
        test_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
